// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter feeding the select of a 4:1 channel mux.
// Holds each grant until done, requester drop, or timeout; one idle cycle between grants.
module rr_sel_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       gnt_valid,
  output logic [3:0] gnt_onehot,
  output logic       timeout_err
);

  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 2;
  localparam int unsigned CW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            valid_q, valid_d;
  logic [NCH-1:0]  onehot_q, onehot_d;
  logic            terr_q, terr_d;

  logic            win_found;
  logic [SW-1:0]   win_idx;
  logic [SW-1:0]   cand;
  logic            timeout_hit;
  logic            grant_end;

  // Rotating priority scan: descending loop so the entry closest to ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = ptr_q + SW'(i);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign grant_end   = done || !req[sel_q] || timeout_hit;

  // Next-state and registered-output logic; sel holds its value whenever no grant is live.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    onehot_d = onehot_q;
    terr_d   = 1'b0;

    unique case (state_q)
      IDLE, RELEASE: begin
        valid_d  = 1'b0;
        onehot_d = '0;
        state_d  = IDLE;
        if (win_found) begin
          state_d  = GRANT;
          sel_d    = win_idx;
          valid_d  = 1'b1;
          onehot_d = NCH'(1) << win_idx;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_d  = RELEASE;
          ptr_d    = sel_q + SW'(1);
          valid_d  = 1'b0;
          onehot_d = '0;
          terr_d   = timeout_hit && !done;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
      terr_q   <= terr_d;
    end
  end

  assign sel         = sel_q;
  assign gnt_valid   = valid_q;
  assign gnt_onehot  = onehot_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed scenarios plus randomized traffic against a
// behavioural grant model.
module tb_rr_sel_arbiter;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       gnt_valid;
  logic [3:0] gnt_onehot;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  rr_sel_arbiter #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .sel         (sel),
    .gnt_valid   (gnt_valid),
    .gnt_onehot  (gnt_onehot),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: who holds the grant, for how long, and who is next in line.
  bit m_busy;      // a channel currently owns the mux
  bit m_gap;       // in the single dead cycle after a grant ended
  int m_owner;     // channel whose select is presented
  int m_age;       // cycles the current owner has held the grant, from 0
  int m_next;      // channel with top priority in the next scan
  bit m_terr;

  function automatic int pick(input int first, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(first + k) % 4]) return (first + k) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    m_terr = 1'b0;
    if (rst) begin
      m_busy = 0; m_gap = 0; m_owner = 0; m_age = 0; m_next = 0;
    end else if (m_busy) begin
      if (done || !req[m_owner] || m_age == TMO - 1) begin
        m_terr = (m_age == TMO - 1) && !done;
        m_next = (m_owner + 1) % 4;
        m_busy = 0;
        m_gap  = 1;
      end else begin
        m_age++;
      end
    end else begin
      m_gap = 0;
      w = pick(m_next, req);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_age = 0;
      end
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] oh;
    oh = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    return {m_terr, m_busy, oh, 2'(m_owner)};
  endfunction

  wire [7:0] obs = {timeout_err, gnt_valid, gnt_onehot, sel};

  // One clock: inputs already stable, model follows the edge, sample on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 1'b1;
    cyc(); cyc();
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++; $display("FAIL reset_values got=%h want=00", obs);
    end
    rst = 1'b0; req = '0; done = 1'b0;
    cyc();
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++; $display("FAIL idle_after_reset got=%h want=00", obs);
    end
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b0101;
    cyc();
    n_tests++;
    if (sel !== 2'd0 || gnt_onehot !== 4'b0001 || gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_first sel=%0d oh=%b v=%b want 0/0001/1", sel, gnt_onehot, gnt_valid);
    end
    done = 1'b1; cyc(); done = 1'b0;
    n_tests++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000 || sel !== 2'd0) begin
      n_fail++; $display("FAIL basic_gap v=%b oh=%b sel=%0d want 0/0000/0", gnt_valid, gnt_onehot, sel);
    end
    cyc();
    n_tests++;
    if (sel !== 2'd2 || gnt_onehot !== 4'b0100 || gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_second sel=%0d oh=%b v=%b want 2/0100/1", sel, gnt_onehot, gnt_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_tests++;
      if (gnt_valid !== 1'b1 || sel !== 2'(i % 4)) begin
        n_fail++; $display("FAIL rotation[%0d] sel=%0d v=%b want %0d/1", i, sel, gnt_valid, i % 4);
      end
      done = 1'b1; cyc(); done = 1'b0;
      n_tests++;
      if (gnt_valid !== 1'b0) begin
        n_fail++; $display("FAIL rotation_gap[%0d] v=%b want 0", i, gnt_valid);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010;
    cyc();
    for (int i = 0; i < TMO; i++) begin
      n_tests++;
      if (gnt_valid !== 1'b1 || timeout_err !== 1'b0 || sel !== 2'd1) begin
        n_fail++; $display("FAIL timeout_hold[%0d] v=%b terr=%b sel=%0d want 1/0/1", i, gnt_valid, timeout_err, sel);
      end
      cyc();
    end
    n_tests++;
    if (gnt_valid !== 1'b0 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_fire v=%b terr=%b want 0/1", gnt_valid, timeout_err);
    end
    cyc();
    n_tests++;
    if (gnt_valid !== 1'b1 || timeout_err !== 1'b0 || sel !== 2'd1) begin
      n_fail++; $display("FAIL timeout_regrant v=%b terr=%b sel=%0d want 1/0/1", gnt_valid, timeout_err, sel);
    end
  endtask

  task automatic test_drop_wrap();
    do_reset();
    req = 4'b1000;
    cyc();
    n_tests++;
    if (sel !== 2'd3 || gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_grant sel=%0d v=%b want 3/1", sel, gnt_valid);
    end
    req = 4'b0000;
    cyc(); cyc();
    n_tests++;
    if (gnt_valid !== 1'b0 || sel !== 2'd3 || gnt_onehot !== 4'b0000) begin
      n_fail++; $display("FAIL drop_idle v=%b sel=%0d oh=%b want 0/3/0000", gnt_valid, sel, gnt_onehot);
    end
    req = 4'b1001;
    cyc();
    n_tests++;
    if (sel !== 2'd0 || gnt_onehot !== 4'b0001) begin
      n_fail++; $display("FAIL drop_wrap sel=%0d oh=%b want 0/0001", sel, gnt_onehot);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_tests++;
    if (sel !== 2'd0 || gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid sel=%0d v=%b oh=%b want 0/0/0000", sel, gnt_valid, gnt_onehot);
    end
    req = 4'b0110;
    cyc();
    n_tests++;
    if (sel !== 2'd1 || gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_after sel=%0d v=%b want 1/1", sel, gnt_valid);
    end
  endtask

  task automatic test_done_vs_timeout();
    do_reset();
    req = 4'b0001;
    cyc();
    for (int i = 0; i < TMO - 1; i++) cyc();
    done = 1'b1; cyc(); done = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0 || gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_beats_timeout terr=%b v=%b want 0/0", timeout_err, gnt_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
      done = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      cyc();
      n_tests++;
      if (obs !== model_vec()) begin
        n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, obs, model_vec());
      end
      if ($countones(gnt_onehot) > 1) begin
        n_fail++; $display("FAIL random_onehot[%0d] oh=%b", i, gnt_onehot);
      end
    end
    rst = 1'b0; done = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;
    m_busy = 0; m_gap = 0; m_owner = 0; m_age = 0; m_next = 0; m_terr = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_drop_wrap();
    test_reset_mid_grant();
    test_done_vs_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
